// File: rtl/div_8bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH steps per operation.
// A zero divisor short-circuits to quotient=all ones, remainder=dividend after a single step.
module div_8bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] remo_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] sum;
  logic             qbit;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;

  // The dividend register doubles as the quotient shift register: each step
  // consumes its MSB into the partial remainder and shifts the new quotient bit in.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    sum     = {1'b0, shifted} + {1'b0, ~{1'b0, dsr_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    // With no borrow the trial is below the divisor, so its top bit is always 0.
    qbit    = sum[WIDTH+1] & ~sum[WIDTH];
    rem_d   = qbit ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_d   = {dvd_q[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q   <= dividend;
            dsr_q   <= divisor;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (dsr_q == '0) begin
            quo_q   <= '1;
            remo_q  <= dvd_q;
            dbz_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
              quo_q   <= dvd_d;
              remo_q  <= rem_d;
              dbz_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_8bit_seq.sv
// Directed and swept checks of div_8bit_seq: latency, results, divide-by-zero,
// reset abort and start-ignored-while-busy behaviour.
module tb_div_8bit_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int errors = 0;
  int checks = 0;

  div_8bit_seq #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check latency, busy span, results and the single done pulse.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int eq, input int er, input int edz, input int lat);
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy_cycles"}, busy_cnt, lat);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    chk({tag, "_quotient"}, int'(quotient), eq);
    chk({tag, "_remainder"}, int'(remainder), er);
    chk({tag, "_dbz"}, int'(div_by_zero), edz);
    tick();
    chk({tag, "_done_drops"}, int'(done), 0);
    chk({tag, "_q_holds"}, int'(quotient), eq);
  endtask

  initial begin
    int dn;
    int a;
    int b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    tick();

    run_op("d100_7", 8'd100, 8'd7, 14, 2, 0, 8);
    run_op("d255_1", 8'd255, 8'd1, 255, 0, 0, 8);
    run_op("d5_9", 8'd5, 8'd9, 0, 5, 0, 8);
    run_op("d255_255", 8'd255, 8'd255, 1, 0, 0, 8);
    run_op("dz5A", 8'h5A, 8'd0, 255, 90, 1, 1);
    run_op("d10_3", 8'd10, 8'd3, 3, 1, 0, 8);

    // Abort 200/3 with reset at E4 while start is also held high.
    dividend = 8'd200;
    divisor  = 8'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    tick();
    rst   = 1'b0;
    start = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) dn++;
      tick();
    end
    chk("abort_no_done", dn, 0);
    chk("abort_idle_busy", int'(busy), 0);
    run_op("d200_3", 8'd200, 8'd3, 66, 2, 0, 8);

    // Start pulses at E3 and in the DONE cycle must be ignored.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd2;
    tick();
    start = 1'b0;
    dn = 0;
    for (int i = 0; i < 24; i++) begin
      if (done === 1'b1) begin
        dn++;
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("ign_done_count", dn, 1);
    chk("ign_quotient", int'(quotient), 14);
    chk("ign_remainder", int'(remainder), 2);
    chk("ign_busy", int'(busy), 0);

    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = (i % 16 == 0) ? 0 : int'($urandom_range(0, 255));
      if (b == 0) begin
        run_op("sweep_dz", 8'(a), 8'd0, 255, a, 1, 1);
      end else begin
        run_op("sweep", 8'(a), 8'(b), a / b, a % b, 0, 8);
        chk("sweep_identity", int'(quotient) * b + int'(remainder), a);
        chk("sweep_rem_lt_div", int'(int'(remainder) < b), 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
